// File: rtl/barrel_pkg.sv
// Shared constants for the left funnel shifter / normaliser.
package barrel_pkg;

  localparam int DEF_WIDTH       = 64;
  localparam int DEF_SHIFT_WIDTH = 6;
  localparam int DEF_SHIFT_MAX   = 46;
  localparam int LZC_W           = DEF_SHIFT_WIDTH;

  // Shift amount is split into a coarse part (multiples of this step) and a fine remainder.
  function automatic int coarse_step();
    return 8;
  endfunction

endpackage

// File: rtl/barrel_lzc.sv
// Combinational leading-zero / leading-sign-bit counter, saturating at CAP.
module barrel_lzc
  import barrel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = LZC_W,
  parameter int CAP   = DEF_SHIFT_MAX
) (
  input  logic [WIDTH-1:0] data,
  input  logic             is_signed,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] scan;
  int               lead;

  always_comb begin
    // Signed: bits matching the MSB become zeros; the MSB itself is dropped and a stop bit appended.
    scan = is_signed ? {data[WIDTH-2:0] ^ {(WIDTH-1){data[WIDTH-1]}}, 1'b1} : data;
    lead = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (scan[i]) lead = WIDTH - 1 - i;
    end
    count = (lead > CAP) ? CW'(CAP) : CW'(lead);
  end

endmodule

// File: rtl/barrel_lnorm.sv
// Three-stage left funnel shifter / normaliser with valid/ready and whole-pipeline stall.
module barrel_lnorm
  import barrel_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int SHIFT_MAX   = DEF_SHIFT_MAX
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   is_signed,
  input  logic                   norm,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [WIDTH-1:0]       in,
  input  logic [WIDTH-1:0]       ex,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_ovf
);

  localparam int STEP   = coarse_step();
  localparam int FINE_W = $clog2(STEP);

  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  // S0: register the beat together with its effective shift
  logic [SHIFT_WIDTH-1:0] lead_count, s_next;
  logic                   valid0_reg, signed0_reg, norm0_reg;
  logic [WIDTH-1:0]       in0_reg, ex0_reg;
  logic [SHIFT_WIDTH-1:0] s0_reg;

  barrel_lzc #(.WIDTH(WIDTH), .CW(SHIFT_WIDTH), .CAP(SHIFT_MAX)) u_lzc (
    .data      (in),
    .is_signed (is_signed),
    .count     (lead_count)
  );

  assign s_next = norm ? lead_count : shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid0_reg  <= 1'b0;
      signed0_reg <= 1'b0;
      norm0_reg   <= 1'b0;
      in0_reg     <= '0;
      ex0_reg     <= '0;
      s0_reg      <= '0;
    end else if (adv) begin
      valid0_reg <= in_valid;
      if (in_valid) begin
        signed0_reg <= is_signed;
        norm0_reg   <= norm;
        in0_reg     <= in;
        ex0_reg     <= ex;
        s0_reg      <= s_next;
      end
    end
  end

  // S1: coarse shift keeps STEP extra low bits for the fine stage; out-of-range selects ex
  logic                    big, ovf1_next;
  logic [WIDTH+STEP-1:0]   coarse_keep, data1_next;
  logic [FINE_W-1:0]       fine1_next;
  logic [WIDTH-1:0]        sign_diff, ovf_mask;
  logic                    valid1_reg, ovf1_reg;
  logic [WIDTH+STEP-1:0]   data1_reg;
  logic [FINE_W-1:0]       fine1_reg;
  logic [SHIFT_WIDTH-1:0]  s1_reg;

  assign big         = s0_reg > SHIFT_WIDTH'(SHIFT_MAX);
  assign coarse_keep = (WIDTH+STEP)'(({in0_reg, ex0_reg} << (s0_reg & ~SHIFT_WIDTH'(STEP-1))) >> (WIDTH-STEP));
  assign data1_next  = big ? {ex0_reg, {STEP{1'b0}}} : coarse_keep;
  assign fine1_next  = big ? '0 : s0_reg[FINE_W-1:0];
  // Overflow when any of the s bits just below the MSB differs from the MSB
  assign sign_diff   = in0_reg ^ {WIDTH{in0_reg[WIDTH-1]}};
  assign ovf_mask    = ~({WIDTH{1'b1}} >> s0_reg) >> 1;
  assign ovf1_next   = signed0_reg & ~norm0_reg & ~big & (|(sign_diff & ovf_mask));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid1_reg <= 1'b0;
      data1_reg  <= '0;
      fine1_reg  <= '0;
      s1_reg     <= '0;
      ovf1_reg   <= 1'b0;
    end else if (adv) begin
      valid1_reg <= valid0_reg;
      if (valid0_reg) begin
        data1_reg <= data1_next;
        fine1_reg <= fine1_next;
        s1_reg    <= s0_reg;
        ovf1_reg  <= ovf1_next;
      end
    end
  end

  // S2: fine shift into the output registers
  logic                   valid2_reg, ovf2_reg;
  logic [WIDTH-1:0]       out_reg, out_next;
  logic [SHIFT_WIDTH-1:0] s2_reg;

  assign out_next = WIDTH'((data1_reg << fine1_reg) >> STEP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid2_reg <= 1'b0;
      out_reg    <= '0;
      s2_reg     <= '0;
      ovf2_reg   <= 1'b0;
    end else if (adv) begin
      valid2_reg <= valid1_reg;
      if (valid1_reg) begin
        out_reg  <= out_next;
        s2_reg   <= s1_reg;
        ovf2_reg <= ovf1_reg;
      end
    end
  end

  assign out_valid = valid2_reg;
  assign out       = out_reg;
  assign out_shift = s2_reg;
  assign out_ovf   = ovf2_reg;

endmodule
